ntlm_hash_reg: RTL and testbench

- Registered NTLM hash engine for the password-cracker datapath.
- Takes a candidate ASCII password (up to 15 chars) plus its length from the guess generator.
- Computes NTLM = MD4(UTF-16LE(password)) in a single block.
- Registers the 128-bit digest alongside a copy of the password, so the downstream comparator and controller see each hash paired with the string that produced it.

---
 rtl/ntlm_hash_reg.sv | 113 +++++++++++
 tb/tb_ntlm_hash_reg.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/ntlm_hash_reg.sv
// ntlm_hash_reg
// Registered single-block NTLM engine: hash = MD4(UTF-16LE(instr[0:L-1])).
// The MD4 compression is fully combinational; the digest and the string
// that produced it are captured together on every rising edge.
//
// Ports
//   clk     in   1       rising-edge clock
//   n_rst   in   1       synchronous reset, active HIGH despite the name
//   instr   in   [0:127] candidate password, instr[8i +: 8] = char i
//   length  in   [0:3]   number of valid characters 0..15
//   hash    out  [0:127] NTLM digest, hash[0:7] = digest byte 0
//   outstr  out  [0:127] instr value that produced the current hash
module ntlm_hash_reg (
  input  logic         clk,
  input  logic         n_rst,
  input  logic [0:127] instr,
  input  logic [0:3]   length,
  output logic [0:127] hash,
  output logic [0:127] outstr
);

  localparam logic [31:0] A0 = 32'h67452301;
  localparam logic [31:0] B0 = 32'hEFCDAB89;
  localparam logic [31:0] C0 = 32'h98BADCFE;
  localparam logic [31:0] D0 = 32'h10325476;

  function automatic logic [31:0] rotl(input logic [31:0] x, input logic [4:0] s);
    return (x << s) | (x >> (6'd32 - {1'b0, s}));
  endfunction

  // Little-endian word -> byte stream order.
  function automatic logic [31:0] bswap(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  function automatic logic [4:0] shamt(input int rnd, input int pos);
    logic [4:0] s;
    s = 5'd0;
    case (rnd)
      0: case (pos) 0: s = 5'd3; 1: s = 5'd7;  2: s = 5'd11; default: s = 5'd19; endcase
      1: case (pos) 0: s = 5'd3; 1: s = 5'd5;  2: s = 5'd9;  default: s = 5'd13; endcase
      default:
         case (pos) 0: s = 5'd3; 1: s = 5'd9;  2: s = 5'd11; default: s = 5'd15; endcase
    endcase
    return s;
  endfunction

  logic [7:0]   w_msg [64];
  logic [31:0]  w_m   [16];
  logic [0:127] w_digest;
  logic [0:127] r_hash;
  logic [0:127] r_outstr;

  // UTF-16LE expansion plus MD padding; everything past the 0x80 marker
  // is zero except the bit count in M14 (16*L always fits in one byte).
  always_comb begin
    for (int b = 0; b < 64; b++) w_msg[b] = 8'h00;
    for (int i = 0; i < 15; i++)
      if (4'(i) < length) w_msg[2*i] = instr[8*i +: 8];
    w_msg[{length, 1'b0}] = 8'h80;
    w_msg[56] = {length, 4'b0000};
    for (int k = 0; k < 16; k++)
      w_m[k] = {w_msg[4*k+3], w_msg[4*k+2], w_msg[4*k+1], w_msg[4*k]};
  end

  // 48 MD4 steps unrolled. After each step the roles rotate
  // (a,b,c,d) <= (d,new,b,c) so the same step body serves every position.
  always_comb begin
    logic [31:0] va, vb, vc, vd, vf, vk, vt;
    logic [3:0]  vj, idx;
    logic [4:0]  vs;
    va = A0; vb = B0; vc = C0; vd = D0;
    vf = '0; vk = '0; vt = '0; vj = '0; idx = '0; vs = '0;
    for (int i = 0; i < 48; i++) begin
      vj = 4'(i % 16);
      vs = shamt(i / 16, i % 4);
      case (i / 16)
        0: begin
          vf  = (vb & vc) | (~vb & vd);
          vk  = 32'h0;
          idx = vj;
        end
        1: begin
          vf  = (vb & vc) | (vb & vd) | (vc & vd);
          vk  = 32'h5A827999;
          idx = {vj[1:0], vj[3:2]};             // 0,4,8,12,1,5,...
        end
        default: begin
          vf  = vb ^ vc ^ vd;
          vk  = 32'h6ED9EBA1;
          idx = {vj[0], vj[1], vj[2], vj[3]};   // bit-reversed: 0,8,4,12,...
        end
      endcase
      vt = rotl(va + vf + w_m[idx] + vk, vs);
      va = vd; vd = vc; vc = vb; vb = vt;
    end
    w_digest = {bswap(va + A0), bswap(vb + B0), bswap(vc + C0), bswap(vd + D0)};
  end

  always_ff @(posedge clk) begin
    if (n_rst) begin
      r_hash   <= '0;
      r_outstr <= '0;
    end else begin
      r_hash   <= w_digest;
      r_outstr <= instr;
    end
  end

  assign hash   = r_hash;
  assign outstr = r_outstr;

endmodule

// File: tb/tb_ntlm_hash_reg.sv
// Directed bench for ntlm_hash_reg. Known NTLM digests are hard-coded;
// the 15-char and back-to-back cases use a byte-oriented MD4 reference.
module tb_ntlm_hash_reg;

  logic         clk;
  logic         n_rst;
  logic [0:127] instr;
  logic [0:3]   length;
  logic [0:127] hash;
  logic [0:127] outstr;

  int n_chk  = 0;
  int n_pass = 0;

  ntlm_hash_reg dut (
    .clk    (clk),
    .n_rst  (n_rst),
    .instr  (instr),
    .length (length),
    .hash   (hash),
    .outstr (outstr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int R1S [4] = '{3, 7, 11, 19};
  localparam int R2S [4] = '{3, 5, 9, 13};
  localparam int R3S [4] = '{3, 9, 11, 15};
  localparam int R2O [16] = '{0,4,8,12,1,5,9,13,2,6,10,14,3,7,11,15};
  localparam int R3O [16] = '{0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15};

  task automatic chk(input string tag, input logic [0:127] got, input logic [0:127] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, got, exp);
  endtask

  function automatic logic [0:127] str2v(input string s);
    logic [0:127] v;
    v = '0;
    for (int i = 0; i < s.len() && i < 16; i++) v[8*i +: 8] = s[i];
    return v;
  endfunction

  function automatic logic [31:0] rl(input logic [31:0] x, input int s);
    return (x << s) | (x >> (32 - s));
  endfunction

  function automatic logic [0:127] md4_ref(input logic [0:127] s, input int len);
    logic [7:0]  m [64];
    logic [31:0] x [16];
    logic [31:0] st [4];
    logic [31:0] a, b, c, d, f, t;
    logic [0:127] r;
    int k, sh;
    for (int i = 0; i < 64; i++) m[i] = 8'h00;
    for (int i = 0; i < len; i++) m[2*i] = s[8*i +: 8];
    m[2*len] = 8'h80;
    m[56] = 8'(len * 16);
    for (int j = 0; j < 16; j++)
      x[j] = {m[4*j+3], m[4*j+2], m[4*j+1], m[4*j]};
    a = 32'h67452301; b = 32'hEFCDAB89; c = 32'h98BADCFE; d = 32'h10325476;
    for (int i = 0; i < 48; i++) begin
      if (i < 16) begin
        f = (b & c) | (~b & d); k = i; sh = R1S[i%4]; t = a + f + x[k];
      end else if (i < 32) begin
        f = (b & c) | (b & d) | (c & d); k = R2O[i-16]; sh = R2S[i%4];
        t = a + f + x[k] + 32'h5A827999;
      end else begin
        f = b ^ c ^ d; k = R3O[i-32]; sh = R3S[i%4];
        t = a + f + x[k] + 32'h6ED9EBA1;
      end
      t = rl(t, sh);
      a = d; d = c; c = b; b = t;
    end
    st[0] = a + 32'h67452301; st[1] = b + 32'hEFCDAB89;
    st[2] = c + 32'h98BADCFE; st[3] = d + 32'h10325476;
    r = '0;
    for (int w = 0; w < 4; w++)
      for (int j = 0; j < 4; j++)
        r[32*w + 8*j +: 8] = st[w][8*j +: 8];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input logic [0:127] s, input int len);
    instr  = s;
    length = 4'(len);
  endtask

  logic [0:127] pw, pwg, s15, q [4];
  int           ql [4];

  initial begin
    pw  = str2v("password");
    pwg = pw;
    pwg[64:127] = 64'hDEADBEEF_CAFEF00D;
    s15 = str2v("Password1234567");
    s15[120:127] = 8'hA5;          // byte 15 must be ignored

    // reset with arbitrary input present
    n_rst = 1'b1;
    apply(pwg, 8);
    tick(); tick();
    chk("rst_hash",   hash,   128'h0);
    chk("rst_outstr", outstr, 128'h0);

    n_rst = 1'b0;
    apply(128'h0, 0);
    tick();
    chk("empty_hash",   hash,   128'h31D6CFE0D16AE931B73C59D7E0C089C0);
    chk("empty_outstr", outstr, 128'h0);

    apply(str2v("a"), 1);
    tick();
    chk("a_hash",   hash,   128'h186CB09181E2C2ECAAC768C47C729904);
    chk("a_outstr", outstr, str2v("a"));

    apply(pw, 8);
    tick();
    chk("pw_hash",   hash,   128'h8846F7EAEE8FB117AD06BDD830B7586C);
    chk("pw_outstr", outstr, pw);

    apply(pwg, 8);
    tick();
    chk("pwg_hash",   hash,   128'h8846F7EAEE8FB117AD06BDD830B7586C);
    chk("pwg_outstr", outstr, pwg);

    apply(s15, 15);
    tick();
    chk("len15_hash",   hash,   md4_ref(s15, 15));
    chk("len15_outstr", outstr, s15);

    // same 15 chars but length 14: last char must drop out
    apply(s15, 14);
    tick();
    chk("len14_hash", hash, md4_ref(s15, 14));

    // back-to-back, new guess every cycle
    q[0] = str2v("abc");    ql[0] = 3;
    q[1] = str2v("admin");  ql[1] = 5;
    q[2] = str2v("123456"); ql[2] = 6;
    q[3] = pwg;             ql[3] = 8;
    for (int i = 0; i < 4; i++) begin
      apply(q[i], ql[i]);
      tick();
      chk($sformatf("b2b%0d_hash", i),   hash,   md4_ref(q[i], ql[i]));
      chk($sformatf("b2b%0d_outstr", i), outstr, q[i]);
    end

    // reset mid-stream discards the guess in flight
    apply(str2v("hello"), 5);
    n_rst = 1'b1;
    tick();
    chk("mid_rst_hash",   hash,   128'h0);
    chk("mid_rst_outstr", outstr, 128'h0);
    n_rst = 1'b0;
    apply(str2v("a"), 1);
    tick();
    chk("post_rst_hash",   hash,   128'h186CB09181E2C2ECAAC768C47C729904);
    chk("post_rst_outstr", outstr, str2v("a"));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
